// File: rtl/regfile_pkg.sv
// Shared definitions for the integer and FP register files.
// Holds the default geometry, address/data typedefs built from it and the
// hardwired-zero register address.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]   rf_addr_t;
  typedef logic [XLEN_DEF-1:0] rf_data_t;

  localparam rf_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard tracking in-flight producers.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears all bits)
//   rsv_en, rsv_addr mark a register busy for an issuing instruction
//   wr_en, wr_addr   writeback lanes; a completing write clears busy
//   flush            clear every busy bit
//   busy             current busy vector, bit 0 is always 0
// Next-state priority per register: flush, then reserve, then write, then hold.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              flush,
  output logic [NREG-1:0]   busy
);

  logic [NREG-1:0] busy_nxt;
  logic            wr_hit;

  always_comb begin
    busy_nxt = busy;
    wr_hit   = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      wr_hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) wr_hit = 1'b1;
      end
      if (flush) begin
        busy_nxt[r] = 1'b0;
      end else if (rsv_en && (rsv_addr == AW'(r))) begin
        // A new producer outranks a write completing in the same cycle.
        busy_nxt[r] = 1'b1;
      end else if (wr_hit) begin
        busy_nxt[r] = 1'b0;
      end
    end
    // Register 0 never has a producer, so a reserve of it is dropped here.
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardwired-zero x0, same-cycle
// write-to-read bypass and a busy scoreboard.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset (clears data and busy)
//   rd_addr_i        NRD read addresses, port k at [k*AW +: AW]
//   rd_data_o        NRD combinational read data, port k at [k*XLEN +: XLEN]
//   rd_busy_o        per read port: addressed register has an outstanding producer
//   wr_en_i, wr_addr_i, wr_data_i   NWR writeback lanes, highest index wins
//   rsv_en_i, rsv_addr_i            reserve a destination register
//   flush_i          clear all busy bits, data kept
// There is no handshake: every enable is qualified per cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                rsv_en_i,
  input  logic [AW-1:0]       rsv_addr_i,
  input  logic                flush_i
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [AW-1:0]   wr_addr [NWR];
  logic [XLEN-1:0] wr_data [NWR];

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wr_addr[j] = wr_addr_i[j*AW +: AW];
    assign wr_data[j] = wr_data_i[j*XLEN +: XLEN];
  end

  // Lanes are applied in ascending order, so the highest-index lane that
  // targets an address lands last and wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_i[j] && (wr_addr[j] != ZERO_ADDR)) mem[wr_addr[j]] <= wr_data[j];
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .rsv_en   (rsv_en_i),
    .rsv_addr (rsv_addr_i),
    .wr_en    (wr_en_i),
    .wr_addr  (wr_addr_i),
    .flush    (flush_i),
    .busy     (busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rd_addr_i[k*AW +: AW];

    always_comb begin
      data = mem[addr];
      bsy  = busy[addr];
      // Bypass: a write in flight this cycle supplies the value and means
      // the producer has completed.
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_i[j] && (wr_addr[j] == addr)) begin
          data = wr_data[j];
          bsy  = 1'b0;
        end
      end
      // x0 reads zero; during reset nothing, including the bypass, leaks out.
      if (!rst_n_i || (addr == ZERO_ADDR)) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = data;
    assign rd_busy_o[k]              = bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (A) and a
// NREG=16/NRD=3/NWR=1/XLEN=64 instance (B). The driver pushes expected read
// results into exp_q; the monitor pops and compares on every falling edge.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // Instance A: defaults.
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;
  logic        a_flush;

  // Instance B: sweep configuration.
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic [0:0]   b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_rsv_en;
  logic [3:0]   b_rsv_addr;
  logic         b_flush;

  regfile_mp u_dut_a (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rd_addr_i  (a_rd_addr),
    .rd_data_o  (a_rd_data),
    .rd_busy_o  (a_rd_busy),
    .wr_en_i    (a_wr_en),
    .wr_addr_i  (a_wr_addr),
    .wr_data_i  (a_wr_data),
    .rsv_en_i   (a_rsv_en),
    .rsv_addr_i (a_rsv_addr),
    .flush_i    (a_flush)
  );

  regfile_mp #(
    .XLEN (64),
    .NREG (16),
    .NRD  (3),
    .NWR  (1)
  ) u_dut_b (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rd_addr_i  (b_rd_addr),
    .rd_data_o  (b_rd_data),
    .rd_busy_o  (b_rd_busy),
    .wr_en_i    (b_wr_en),
    .wr_addr_i  (b_wr_addr),
    .wr_data_i  (b_wr_data),
    .rsv_en_i   (b_rsv_en),
    .rsv_addr_i (b_rsv_addr),
    .flush_i    (b_flush)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  // Entry: {sel, port[1:0], busy, data[63:0]}; sel 0 = instance A, 1 = B.
  localparam int EW = 68;
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks;
  int            errors;

  task automatic expect_rd(input logic sel, input logic [1:0] port,
                           input logic [63:0] data, input logic busy, input string name);
    exp_q.push_back({sel, port, busy, data});
    name_q.push_back(name);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      string         nm;
      logic [63:0]   act_d;
      logic          act_b;
      int            p;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      p  = int'(e[66:65]);
      if (e[67]) begin
        act_d = b_rd_data[p*64 +: 64];
        act_b = b_rd_busy[p];
      end else begin
        act_d = {32'h0, a_rd_data[p*32 +: 32]};
        act_b = a_rd_busy[p];
      end
      checks++;
      if (act_d !== e[63:0] || act_b !== e[64]) begin
        errors++;
        $display("FAIL %s: port %0d got data=%h busy=%b, required data=%h busy=%b",
                 nm, p, act_d, act_b, e[63:0], e[64]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr_en  = '0;
    a_rsv_en = 1'b0;
    a_flush  = 1'b0;
  endtask

  task automatic a_rd(input logic [4:0] p0, input logic [4:0] p1);
    a_rd_addr = {p1, p0};
  endtask

  task automatic a_wr(input int port, input logic [4:0] addr, input logic [31:0] data);
    a_wr_en[port]              = 1'b1;
    a_wr_addr[port*5 +: 5]     = addr;
    a_wr_data[port*32 +: 32]   = data;
  endtask

  task automatic a_rsv(input logic [4:0] addr);
    a_rsv_en   = 1'b1;
    a_rsv_addr = addr;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_rsv_en = 1'b0; a_rsv_addr = '0; a_flush = 1'b0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;
    #1;

    // Reset: reads are zero, and a write during reset is discarded.
    a_rd(5'd5, 5'd31);
    a_wr(0, 5'd5, 32'hAAAA_5555);
    a_rsv(5'd31);
    expect_rd(0, 0, 64'h0, 1'b0, "reset_rd5");
    expect_rd(0, 1, 64'h0, 1'b0, "reset_rd31");
    step();
    step();
    rst_n = 1'b1;
    a_idle();
    step();
    expect_rd(0, 0, 64'h0, 1'b0, "post_reset_rd5");
    expect_rd(0, 1, 64'h0, 1'b0, "post_reset_rd31");
    step();

    // Write with bypass, then from the array.
    a_rd(5'd0, 5'd7);
    a_wr(0, 5'd7, 32'hDEAD_BEEF);
    expect_rd(0, 1, 64'hDEAD_BEEF, 1'b0, "bypass_rd7");
    step();
    a_idle();
    expect_rd(0, 1, 64'hDEAD_BEEF, 1'b0, "array_rd7");
    step();

    // x0 is never written.
    a_rd(5'd0, 5'd7);
    a_wr(0, 5'd0, 32'h1234);
    expect_rd(0, 0, 64'h0, 1'b0, "x0_bypass");
    step();
    a_idle();
    expect_rd(0, 0, 64'h0, 1'b0, "x0_array");
    step();

    // Same-address conflict: lane 1 wins.
    a_rd(5'd3, 5'd7);
    a_wr(0, 5'd3, 32'h11);
    a_wr(1, 5'd3, 32'h22);
    expect_rd(0, 0, 64'h22, 1'b0, "conflict_bypass");
    step();
    a_idle();
    expect_rd(0, 0, 64'h22, 1'b0, "conflict_array");
    expect_rd(0, 1, 64'hDEAD_BEEF, 1'b0, "conflict_rd7_kept");
    step();

    // Scoreboard on register 9.
    a_rd(5'd9, 5'd3);
    a_rsv(5'd9);
    expect_rd(0, 0, 64'h0, 1'b0, "rsv_same_cycle");
    step();
    a_idle();
    expect_rd(0, 0, 64'h0, 1'b1, "rsv_next_cycle");
    step();
    a_wr(0, 5'd9, 32'h55);
    expect_rd(0, 0, 64'h55, 1'b0, "wr_clears_bypass");
    step();
    a_idle();
    expect_rd(0, 0, 64'h55, 1'b0, "wr_cleared_array");
    step();
    a_wr(1, 5'd9, 32'h55);
    a_rsv(5'd9);
    expect_rd(0, 0, 64'h55, 1'b0, "rsv_wr_same_bypass");
    step();
    a_idle();
    expect_rd(0, 0, 64'h55, 1'b1, "rsv_beats_wr");
    step();

    // Flush: reserve 4, 6, 8 (4 holds data), then flush with a reserve of 10.
    a_wr(0, 5'd4, 32'h44);
    step();
    a_idle();
    a_rsv(5'd4);
    step();
    a_rsv(5'd6);
    step();
    a_rsv(5'd8);
    step();
    a_idle();
    a_rd(5'd4, 5'd6);
    expect_rd(0, 0, 64'h44, 1'b1, "pre_flush_rd4");
    expect_rd(0, 1, 64'h0, 1'b1, "pre_flush_rd6");
    step();
    a_rd(5'd8, 5'd10);
    a_flush = 1'b1;
    a_rsv(5'd10);
    expect_rd(0, 0, 64'h0, 1'b1, "flush_cycle_rd8");
    expect_rd(0, 1, 64'h0, 1'b0, "flush_cycle_rd10");
    step();
    a_idle();
    expect_rd(0, 0, 64'h0, 1'b0, "post_flush_rd8");
    expect_rd(0, 1, 64'h0, 1'b0, "post_flush_rd10");
    step();
    a_rd(5'd4, 5'd9);
    expect_rd(0, 0, 64'h44, 1'b0, "post_flush_rd4");
    expect_rd(0, 1, 64'h55, 1'b0, "post_flush_rd9");
    step();
    a_rd(5'd6, 5'd3);
    expect_rd(0, 0, 64'h0, 1'b0, "post_flush_rd6");
    expect_rd(0, 1, 64'h22, 1'b0, "post_flush_rd3");
    step();

    // Sweep instance: 64-bit data, 16 registers, 3 read ports, 1 write port.
    b_rd_addr = {4'd15, 4'd0, 4'd15};
    b_wr_en   = 1'b1;
    b_wr_addr = 4'd15;
    b_wr_data = 64'hFFFF_FFFF_0000_0001;
    expect_rd(1, 0, 64'hFFFF_FFFF_0000_0001, 1'b0, "b_bypass_p0");
    expect_rd(1, 1, 64'h0, 1'b0, "b_x0_p1");
    expect_rd(1, 2, 64'hFFFF_FFFF_0000_0001, 1'b0, "b_bypass_p2");
    step();
    b_wr_en = 1'b0;
    expect_rd(1, 2, 64'hFFFF_FFFF_0000_0001, 1'b0, "b_array_p2");
    step();
    b_rd_addr = {4'd15, 4'd0, 4'd3};
    b_wr_en   = 1'b1;
    b_wr_addr = 4'd0;
    b_wr_data = 64'h1234;
    b_rsv_en  = 1'b1;
    b_rsv_addr = 4'd3;
    expect_rd(1, 1, 64'h0, 1'b0, "b_x0_bypass");
    expect_rd(1, 0, 64'h0, 1'b0, "b_rsv_same_cycle");
    step();
    b_wr_en  = 1'b0;
    b_rsv_en = 1'b0;
    expect_rd(1, 1, 64'h0, 1'b0, "b_x0_array");
    expect_rd(1, 0, 64'h0, 1'b1, "b_rsv_next_cycle");
    step();
    b_wr_en   = 1'b1;
    b_wr_addr = 4'd3;
    b_wr_data = 64'h0123_4567_89AB_CDEF;
    expect_rd(1, 0, 64'h0123_4567_89AB_CDEF, 1'b0, "b_wr_clears_bypass");
    step();
    b_wr_en = 1'b0;
    expect_rd(1, 0, 64'h0123_4567_89AB_CDEF, 1'b0, "b_wr_cleared_array");
    expect_rd(1, 2, 64'hFFFF_FFFF_0000_0001, 1'b0, "b_rd15_kept");
    step();

    // Let the monitor drain the final entries.
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
